// File: rtl/shim_ads816x_pkg.sv
// Shared definitions for the ADS816x controller and its command sequencer.
// Command word layout: [31:30] type, [29] trig, [28] cont, [24:0] arg.
package shim_ads816x_pkg;

   localparam logic [1:0]  CMD_NO_OP   = 2'b00;
   localparam logic [1:0]  CMD_ADC_RD  = 2'b01;
   localparam logic [1:0]  CMD_SET_ORD = 2'b10;
   localparam logic [1:0]  CMD_CANCEL  = 2'b11;
   localparam int          TRIG_BIT    = 29;
   localparam int          CONT_BIT    = 28;
   localparam logic [31:0] CANCEL_WORD = 32'hC000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SETUP,
      S_PLAY,
      S_CANCEL,
      S_DONE,
      S_ERROR
   } seq_state_t;

   // NO_OP and ADC_RD carry a continue flag; the other types pass through untouched
   function automatic logic [31:0] forceCont(input logic [31:0] word, input logic isFinal);
      logic [31:0] result;
      result = word;
      if (word[31:30] == CMD_NO_OP || word[31:30] == CMD_ADC_RD)
         result[CONT_BIT] = ~isFinal;
      return result;
   endfunction

endpackage

// File: rtl/shim_seq_prog_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
// The read register holds its value while i_rdEn is low.
module shim_seq_prog_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          i_wrEn,
   input  logic [AW-1:0] i_wrAddr,
   input  logic [31:0]   i_wrData,
   input  logic          i_rdEn,
   input  logic [AW-1:0] i_rdAddr,
   output logic [31:0]   o_rdData
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wrEn)
         r_mem[i_wrAddr] <= i_wrData;
      if (i_rdEn)
         o_rdData <= r_mem[i_rdAddr];
   end

endmodule

// File: rtl/shim_ads816x_adc_seq.sv
// Command sequencer: streams program RAM words into the ADC command FIFO,
// optionally looping, with CANCEL injection on abort and halt on any controller error.
module shim_ads816x_adc_seq
   import shim_ads816x_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int AW         = $clog2(PROG_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_wr_en,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   input  logic [AW:0]   seq_len,
   input  logic [15:0]   loop_count,
   input  logic          start,
   input  logic          abort,
   input  logic          adc_setup_done,
   input  logic          adc_err,
   input  logic          cmd_buf_full,
   output logic          cmd_word_wr_en,
   output logic [31:0]   cmd_word,
   output logic          busy,
   output logic          done,
   output logic          seq_error,
   output logic [15:0]   loops_done
);

   localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(PROG_DEPTH);

   seq_state_t    r_state, w_nextState;
   logic [AW:0]   r_seqLen;
   logic [15:0]   r_loopCount;
   logic [AW-1:0] r_fetchPtr, r_pc;
   logic [15:0]   r_fetchPass, r_loopsDone;
   logic          r_fetchDone, r_valid, r_seqError;
   logic [31:0]   w_ramData;
   logic          w_busy, w_err, w_write, w_fetch, w_startBad;
   logic          w_finite, w_pcLast, w_fetchLast, w_lastPass, w_fetchLastPass, w_finalWord;

   assign w_busy          = (r_state != S_IDLE) && (r_state != S_ERROR);
   assign w_finite        = (r_loopCount != 16'd0);
   assign w_pcLast        = ({1'b0, r_pc} == (r_seqLen - LEN_ONE));
   assign w_fetchLast     = ({1'b0, r_fetchPtr} == (r_seqLen - LEN_ONE));
   assign w_lastPass      = w_finite && (r_loopsDone == (r_loopCount - 16'd1));
   assign w_fetchLastPass = w_finite && (r_fetchPass == (r_loopCount - 16'd1));
   assign w_finalWord     = w_pcLast && w_lastPass;
   assign w_startBad      = (seq_len == '0) || (seq_len > LEN_MAX);

   // Losing setup_done mid-stream means the controller rebooted under us
   assign w_err   = adc_err || ((r_state == S_PLAY) && !adc_setup_done);
   assign w_write = (r_state == S_PLAY) && r_valid && !cmd_buf_full && !w_err;
   assign w_fetch = (r_state == S_PLAY) && !r_fetchDone && (!r_valid || w_write);

   assign busy       = w_busy;
   assign seq_error  = r_seqError;
   assign loops_done = r_loopsDone;

   shim_seq_prog_ram #(
      .DEPTH (PROG_DEPTH),
      .AW    (AW)
   ) u_progRam (
      .clk      (clk),
      .i_wrEn   (prog_wr_en && !w_busy),
      .i_wrAddr (prog_addr),
      .i_wrData (prog_data),
      .i_rdEn   (w_fetch),
      .i_rdAddr (r_fetchPtr),
      .o_rdData (w_ramData)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState    = r_state;
      cmd_word_wr_en = 1'b0;
      cmd_word       = '0;
      done           = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_nextState = w_startBad ? S_ERROR : S_WAIT_SETUP;
         end
         S_WAIT_SETUP: begin
            if (abort)
               w_nextState = S_DONE;
            else if (adc_setup_done)
               w_nextState = S_PLAY;
         end
         S_PLAY: begin
            cmd_word_wr_en = w_write;
            if (r_valid)
               cmd_word = forceCont(w_ramData, w_finalWord);
            if (abort)
               w_nextState = S_CANCEL;
            else if (w_write && w_finalWord)
               w_nextState = S_DONE;
         end
         S_CANCEL: begin
            cmd_word       = CANCEL_WORD;
            cmd_word_wr_en = !cmd_buf_full && !w_err;
            if (!cmd_buf_full)
               w_nextState = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_nextState = S_IDLE;
         end
         S_ERROR: w_nextState = S_ERROR;
         default: w_nextState = S_IDLE;
      endcase
      if (w_err)
         w_nextState = S_ERROR;
   end

   // The fetch side runs one word ahead of the write side and stops after the final word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seqLen    <= '0;
         r_loopCount <= '0;
         r_fetchPtr  <= '0;
         r_fetchPass <= '0;
         r_fetchDone <= 1'b0;
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_loopsDone <= '0;
         r_seqError  <= 1'b0;
      end else begin
         if (w_err)
            r_seqError <= 1'b1;
         if ((r_state == S_IDLE) && start && !w_err) begin
            r_seqLen    <= seq_len;
            r_loopCount <= loop_count;
            r_fetchPtr  <= '0;
            r_fetchPass <= '0;
            r_fetchDone <= 1'b0;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_loopsDone <= '0;
            if (w_startBad)
               r_seqError <= 1'b1;
         end
         if (w_fetch) begin
            r_valid <= 1'b1;
            if (w_fetchLast) begin
               r_fetchPtr <= '0;
               if (w_fetchLastPass)
                  r_fetchDone <= 1'b1;
               else
                  r_fetchPass <= r_fetchPass + 16'd1;
            end else begin
               r_fetchPtr <= r_fetchPtr + 1'b1;
            end
         end else if (w_write) begin
            r_valid <= 1'b0;
         end
         if (w_write) begin
            if (w_pcLast) begin
               r_pc <= '0;
               if (r_loopsDone != 16'hFFFF)
                  r_loopsDone <= r_loopsDone + 16'd1;
            end else begin
               r_pc <= r_pc + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_shim_ads816x_adc_seq.sv
// Directed bench for the ADS816x command sequencer: playback, backpressure,
// abort/CANCEL, error halt, setup wait and bad-length handling.
module tb_shim_ads816x_adc_seq;

   localparam int PROG_DEPTH = 16;
   localparam int AW         = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          prog_wr_en = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [31:0]   prog_data = '0;
   logic [AW:0]   seq_len = '0;
   logic [15:0]   loop_count = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          adc_setup_done = 1'b0;
   logic          adc_err = 1'b0;
   logic          cmd_buf_full = 1'b0;
   logic          cmd_word_wr_en;
   logic [31:0]   cmd_word;
   logic          busy;
   logic          done;
   logic          seq_error;
   logic [15:0]   loops_done;

   int          testsRun = 0;
   int          testsFailed = 0;
   int          doneCnt = 0;
   int          fullViol = 0;
   logic [31:0] cap [$];

   logic [31:0] expT1 [6] = '{32'h1000_000A, 32'h5000_0003, 32'h3000_0000,
                              32'h1000_000A, 32'h5000_0003, 32'h2000_0000};
   logic [31:0] expT3 [8] = '{32'h1000_000A, 32'h5000_0003, 32'h3000_0000, 32'h8000_0007,
                              32'h1000_000A, 32'h5000_0003, 32'h3000_0000, 32'hC000_0000};
   logic [31:0] expT5 [3] = '{32'h1000_000A, 32'h5000_0003, 32'h2000_0000};

   shim_ads816x_adc_seq #(
      .PROG_DEPTH (PROG_DEPTH),
      .AW         (AW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .prog_wr_en     (prog_wr_en),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .seq_len        (seq_len),
      .loop_count     (loop_count),
      .start          (start),
      .abort          (abort),
      .adc_setup_done (adc_setup_done),
      .adc_err        (adc_err),
      .cmd_buf_full   (cmd_buf_full),
      .cmd_word_wr_en (cmd_word_wr_en),
      .cmd_word       (cmd_word),
      .busy           (busy),
      .done           (done),
      .seq_error      (seq_error),
      .loops_done     (loops_done)
   );

   always #5 clk = ~clk;

   // Record every FIFO write and done pulse mid-cycle, where inputs are stable
   always @(negedge clk) begin
      if (cmd_word_wr_en) begin
         cap.push_back(cmd_word);
         if (cmd_buf_full)
            fullViol++;
      end
      if (done)
         doneCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(2);
      reset = 1'b0;
   endtask

   task automatic progWord(input logic [AW-1:0] addr, input logic [31:0] data);
      prog_addr  = addr;
      prog_data  = data;
      prog_wr_en = 1'b1;
      applyStimulus(1);
      prog_wr_en = 1'b0;
   endtask

   task automatic startSeq(input logic [AW:0] len, input logic [15:0] loops);
      seq_len    = len;
      loop_count = loops;
      start      = 1'b1;
      applyStimulus(1);
      start      = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int maxCycles, input bit toggleFull);
      int startDone;
      int n;
      startDone = doneCnt;
      n = 0;
      while (doneCnt == startDone && n < maxCycles) begin
         applyStimulus(1);
         if (toggleFull)
            cmd_buf_full = ~cmd_buf_full;
         n++;
      end
      cmd_buf_full = 1'b0;
      checkOutput(tag, 32'(doneCnt != startDone), 32'd1);
   endtask

   task automatic waitWrites(input string tag, input int target, input int maxCycles);
      int n;
      n = 0;
      while (cap.size() < target && n < maxCycles) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput(tag, 32'(cap.size() >= target), 32'd1);
   endtask

   initial begin
      int base;
      int doneBase;
      int frozen;

      adc_setup_done = 1'b1;
      doReset();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset seq_error", 32'(seq_error), 32'd0);
      checkOutput("reset loops_done", 32'(loops_done), 32'd0);
      checkOutput("reset wr_en", 32'(cmd_word_wr_en), 32'd0);
      checkOutput("reset cmd_word", cmd_word, 32'd0);

      progWord(4'd0, 32'h0000_000A);
      progWord(4'd1, 32'h5000_0003);
      progWord(4'd2, 32'h2000_0000);
      progWord(4'd3, 32'h8000_0007);

      // Three-word program, two passes, FIFO always ready
      base = cap.size();
      doneBase = doneCnt;
      startSeq(5'd3, 16'd2);
      waitDone("t1 done seen", 100, 1'b0);
      applyStimulus(2);
      checkOutput("t1 write count", 32'(cap.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("t1 word%0d", i), cap[base + i], expT1[i]);
      checkOutput("t1 loops_done", 32'(loops_done), 32'd2);
      checkOutput("t1 done pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("t1 busy after", 32'(busy), 32'd0);

      // Same program with the FIFO full every other cycle
      base = cap.size();
      startSeq(5'd3, 16'd2);
      waitDone("t2 done seen", 200, 1'b1);
      applyStimulus(2);
      checkOutput("t2 write count", 32'(cap.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("t2 word%0d", i), cap[base + i], expT1[i]);
      checkOutput("t2 writes while full", 32'(fullViol), 32'd0);
      checkOutput("t2 loops_done", 32'(loops_done), 32'd2);

      // Endless loop of four words, abort during the seventh write
      base = cap.size();
      doneBase = doneCnt;
      startSeq(5'd4, 16'd0);
      waitWrites("t3 seven writes", base + 7, 100);
      abort = 1'b1;
      applyStimulus(1);
      abort = 1'b0;
      waitDone("t3 done seen", 50, 1'b0);
      applyStimulus(2);
      checkOutput("t3 write count", 32'(cap.size() - base), 32'd8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("t3 word%0d", i), cap[base + i], expT3[i]);
      checkOutput("t3 loops_done", 32'(loops_done), 32'd1);
      checkOutput("t3 done pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("t3 busy after", 32'(busy), 32'd0);

      // Controller error mid-stream halts everything until reset
      base = cap.size();
      startSeq(5'd3, 16'd0);
      waitWrites("t4 three writes", base + 3, 100);
      applyStimulus(1);
      adc_err = 1'b1;
      #1;
      checkOutput("t4 wr_en on err cycle", 32'(cmd_word_wr_en), 32'd0);
      frozen = cap.size();
      applyStimulus(1);
      adc_err = 1'b0;
      checkOutput("t4 seq_error", 32'(seq_error), 32'd1);
      checkOutput("t4 busy", 32'(busy), 32'd0);
      startSeq(5'd3, 16'd1);
      applyStimulus(10);
      checkOutput("t4 no writes after err", 32'(cap.size()), 32'(frozen));
      checkOutput("t4 start ignored", 32'(busy), 32'd0);
      checkOutput("t4 seq_error sticky", 32'(seq_error), 32'd1);
      doReset();
      checkOutput("t4 seq_error after reset", 32'(seq_error), 32'd0);

      // Hold off until setup_done; first word two clocks after it rises
      adc_setup_done = 1'b0;
      base = cap.size();
      startSeq(5'd3, 16'd1);
      applyStimulus(50);
      checkOutput("t5 no writes before setup", 32'(cap.size() - base), 32'd0);
      checkOutput("t5 busy waiting", 32'(busy), 32'd1);
      adc_setup_done = 1'b1;
      #1;
      checkOutput("t5 wr_en cycle0", 32'(cmd_word_wr_en), 32'd0);
      applyStimulus(1);
      checkOutput("t5 wr_en cycle1", 32'(cmd_word_wr_en), 32'd0);
      applyStimulus(1);
      checkOutput("t5 wr_en cycle2", 32'(cmd_word_wr_en), 32'd1);
      checkOutput("t5 first word", cmd_word, 32'h1000_000A);
      waitDone("t5 done seen", 50, 1'b0);
      applyStimulus(2);
      checkOutput("t5 write count", 32'(cap.size() - base), 32'd3);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("t5 word%0d", i), cap[base + i], expT5[i]);
      checkOutput("t5 loops_done", 32'(loops_done), 32'd1);

      // Illegal lengths go straight to the error state
      startSeq(5'd0, 16'd1);
      checkOutput("t6 len0 seq_error", 32'(seq_error), 32'd1);
      checkOutput("t6 len0 busy", 32'(busy), 32'd0);
      doReset();
      checkOutput("t6 reset clears error", 32'(seq_error), 32'd0);
      startSeq(5'd17, 16'd1);
      checkOutput("t6 len17 seq_error", 32'(seq_error), 32'd1);
      doReset();
      checkOutput("t6 final seq_error", 32'(seq_error), 32'd0);
      checkOutput("t6 final busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
